// File: rtl/matmul_stream.sv
`default_nettype none
// ============================================================================
// Module   : matmul_stream
// Brief    : Handshaked signed N x N matrix multiplier (C = A*B or C += A*B).
//            Output-stationary MAC array stepping k over N cycles.
//            Optional MATMUL_SAT_EN: saturating output conversion and sat_flag.
// Revision : 1.0
// ============================================================================
module matmul_stream #(
   parameter int N         = 2,
   parameter int WIDTH     = 8,
   parameter int ACC_WIDTH = 32,
   parameter int OUT_WIDTH = 8
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic [N*N*WIDTH-1:0]         A_flat,
   input  logic [N*N*WIDTH-1:0]         B_flat,
   input  logic                         accum,
   input  logic                         in_valid,
   output logic                         in_ready,
   output logic [N*N*OUT_WIDTH-1:0]     C_flat,
   output logic                         out_valid,
   input  logic                         out_ready
`ifdef MATMUL_SAT_EN
   ,
   output logic                         sat_flag
`endif
);

   localparam int KW = (N > 1) ? $clog2(N) : 1;

   localparam logic [1:0] IDLE    = 2'd0;
   localparam logic [1:0] COMPUTE = 2'd1;
   localparam logic [1:0] DONE    = 2'd2;

   logic [1:0]                   state;
   logic [KW-1:0]                k;
   logic [N*N*WIDTH-1:0]         a_reg;
   logic [N*N*WIDTH-1:0]         b_reg;
   logic signed [ACC_WIDTH-1:0]  acc      [N*N];
   logic signed [ACC_WIDTH-1:0]  acc_next [N*N];
   logic [N*N*OUT_WIDTH-1:0]     c_next;
   logic [N*N-1:0]               clip;

   assign in_ready = (state == IDLE);

   // One MAC per output element; each consumes column k of A and row k of B.
   for (genvar i = 0; i < N; i++) begin : g_row
      for (genvar j = 0; j < N; j++) begin : g_col
         logic signed [WIDTH-1:0]     a_el;
         logic signed [WIDTH-1:0]     b_el;
         logic signed [2*WIDTH-1:0]   prod;

         assign a_el = a_reg[(i*N + int'(k))*WIDTH +: WIDTH];
         assign b_el = b_reg[(int'(k)*N + j)*WIDTH +: WIDTH];
         assign prod = a_el * b_el;
         assign acc_next[i*N+j] = acc[i*N+j] + ACC_WIDTH'(prod);

`ifdef MATMUL_SAT_EN
         // Fits in OUT_WIDTH iff every bit above the output sign bit matches it.
         logic fits;
         assign fits = (&acc_next[i*N+j][ACC_WIDTH-1:OUT_WIDTH-1]) |
                       (~|acc_next[i*N+j][ACC_WIDTH-1:OUT_WIDTH-1]);
         assign c_next[(i*N+j)*OUT_WIDTH +: OUT_WIDTH] = fits ?
                acc_next[i*N+j][OUT_WIDTH-1:0] :
                {acc_next[i*N+j][ACC_WIDTH-1], {(OUT_WIDTH-1){~acc_next[i*N+j][ACC_WIDTH-1]}}};
         assign clip[i*N+j] = ~fits;
`else
         assign c_next[(i*N+j)*OUT_WIDTH +: OUT_WIDTH] = acc_next[i*N+j][OUT_WIDTH-1:0];
         assign clip[i*N+j] = 1'b0;
`endif
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= IDLE;
         k         <= '0;
         a_reg     <= '0;
         b_reg     <= '0;
         C_flat    <= '0;
         out_valid <= 1'b0;
         for (int e = 0; e < N*N; e++) acc[e] <= '0;
`ifdef MATMUL_SAT_EN
         sat_flag  <= 1'b0;
`endif
      end else begin
         case (state)
            IDLE: begin
               if (in_valid) begin
                  a_reg <= A_flat;
                  b_reg <= B_flat;
                  k     <= '0;
                  if (!accum) begin
                     for (int e = 0; e < N*N; e++) acc[e] <= '0;
                  end
                  state <= COMPUTE;
               end
            end
            COMPUTE: begin
               for (int e = 0; e < N*N; e++) acc[e] <= acc_next[e];
               k <= k + KW'(1);
               // The last step's products go straight into the result register.
               if (k == KW'(N-1)) begin
                  C_flat    <= c_next;
                  out_valid <= 1'b1;
                  state     <= DONE;
`ifdef MATMUL_SAT_EN
                  sat_flag  <= |clip;
`endif
               end
            end
            DONE: begin
               if (out_ready) begin
                  out_valid <= 1'b0;
                  state     <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

`ifndef MATMUL_SAT_EN
   logic unused_clip;
   assign unused_clip = ^clip;
`endif

endmodule
`default_nettype wire
